mc_bus_master: RTL and testbench

- Initiator side of the MCU parallel memory-controller bus (CE/OE/WE strobes, address, 16-bit data).
- Converts a single-beat valid/ready request into a correctly timed bus cycle, with programmable setup, strobe and hold phases.
- Strobe minimums cover the slave's 2-flop strobe synchronizers.
- Used to drive FPGA-side register access in loopback and self-test builds, and as a synthesizable bus driver in benches.
- Split tristate ports feed a top-level SB_IO.

---
 rtl/mc_bus_master.sv | 116 +++++++++++
 tb/tb_mc_bus_master.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mc_bus_master.sv
// Initiator for the MCU parallel memory-controller bus: turns one valid/ready
// request into a CE/OE/WE cycle with programmable setup, strobe and hold phases.
module mc_bus_master #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [MC_ADD_WIDTH-1:0]  req_add,
  input  logic [MC_DATA_WIDTH-1:0] req_wdata,
  output logic                     rsp_valid,
  output logic [MC_DATA_WIDTH-1:0] rsp_rdata,
  output logic                     busy,
  output logic                     mc_ce,
  output logic                     mc_oe,
  output logic                     mc_we,
  output logic [MC_ADD_WIDTH-1:0]  mc_add,
  output logic [MC_DATA_WIDTH-1:0] mc_data_out,
  output logic                     mc_data_oe,
  input  logic [MC_DATA_WIDTH-1:0] mc_data_in
);

  localparam int MAXC = (SETUP_CYCLES > STROBE_CYCLES) ?
                        ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
                        ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int CW = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          wr_q, wr_n, accept, last_strobe;

  assign req_ready   = (state == IDLE);
  assign busy        = !req_ready;
  assign accept      = req_valid && req_ready;
  assign wr_n        = accept ? req_write : wr_q;
  assign last_strobe = (state == STROBE) && (cnt == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // One down-counter times every phase; it is reloaded on each state entry.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (accept) begin
        state_n = SETUP;
        cnt_n   = SETUP_LD;
      end
      SETUP: if (cnt == '0) begin
        state_n = STROBE;
        cnt_n   = STROBE_LD;
      end else cnt_n = cnt - CW'(1);
      STROBE: if (cnt == '0) begin
        state_n = HOLD;
        cnt_n   = HOLD_LD;
      end else cnt_n = cnt - CW'(1);
      HOLD: if (cnt == '0) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else cnt_n = cnt - CW'(1);
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Bus outputs are registered from the next state, so every pin is a flop and
  // the pad timing lines up exactly with the phase boundaries.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q        <= 1'b0;
      mc_ce       <= 1'b1;
      mc_oe       <= 1'b1;
      mc_we       <= 1'b1;
      mc_data_oe  <= 1'b0;
      mc_add      <= '0;
      mc_data_out <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      if (accept) begin
        wr_q   <= req_write;
        mc_add <= req_add;
        if (req_write) mc_data_out <= req_wdata;
      end
      mc_ce      <= (state_n == IDLE);
      mc_we      <= !((state_n == STROBE) && wr_n);
      mc_oe      <= !((state_n == STROBE) && !wr_n);
      mc_data_oe <= (state_n != IDLE) && wr_n;
      rsp_valid  <= last_strobe && !wr_q;
      if (last_strobe && !wr_q) rsp_rdata <= mc_data_in;
    end
  end

endmodule

// File: tb/tb_mc_bus_master.sv
// Bench for mc_bus_master: default-parameter unit and a minimum-timing unit,
// checked cycle by cycle against a phase-window model of the bus cycle.
module tb_mc_bus_master;

  localparam int SP[2] = '{2, 1};
  localparam int TP[2] = '{4, 3};
  localparam int HP[2] = '{2, 1};

  logic clock, reset;
  logic valid[2], write[2], ready[2], rvld[2], busy[2];
  logic ce[2], oe[2], we[2], doe[2];
  logic [5:0]  add[2], madd[2];
  logic [15:0] wdata[2], rdata[2], dout[2], din[2], sval[2];
  logic [15:0] sidx1;
  logic [15:0] last_rd[2];

  int checks = 0;
  int failures = 0;

  mc_bus_master u0 (
    .clock(clock), .reset(reset),
    .req_valid(valid[0]), .req_ready(ready[0]), .req_write(write[0]),
    .req_add(add[0]), .req_wdata(wdata[0]),
    .rsp_valid(rvld[0]), .rsp_rdata(rdata[0]), .busy(busy[0]),
    .mc_ce(ce[0]), .mc_oe(oe[0]), .mc_we(we[0]), .mc_add(madd[0]),
    .mc_data_out(dout[0]), .mc_data_oe(doe[0]), .mc_data_in(din[0])
  );

  mc_bus_master #(.SETUP_CYCLES(1), .STROBE_CYCLES(3), .HOLD_CYCLES(1)) u1 (
    .clock(clock), .reset(reset),
    .req_valid(valid[1]), .req_ready(ready[1]), .req_write(write[1]),
    .req_add(add[1]), .req_wdata(wdata[1]),
    .rsp_valid(rvld[1]), .rsp_rdata(rdata[1]), .busy(busy[1]),
    .mc_ce(ce[1]), .mc_oe(oe[1]), .mc_we(we[1]), .mc_add(madd[1]),
    .mc_data_out(dout[1]), .mc_data_oe(doe[1]), .mc_data_in(din[1])
  );

  // Slave 0 drives a constant while OE is low; slave 1 changes its data every
  // strobe cycle so only a capture at the last strobe cycle gives the right value.
  assign din[0] = oe[0] ? 16'h0000 : sval[0];
  assign din[1] = oe[1] ? 16'h0000 : sval[1] + sidx1;
  always @(posedge clock) sidx1 <= oe[1] ? 16'h0000 : sidx1 + 16'h1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Issue one request on unit u and check every cycle up to and including the
  // first ready cycle. Called and returns at a negedge.
  task automatic run_txn(input int u, input bit wr, input logic [5:0] a,
                         input logic [15:0] wd, input logic [15:0] sv, input bit hold_next);
    int s, t, h, n, wt;
    bit in_str;
    logic [15:0] cap, exp_rd;
    s = SP[u]; t = TP[u]; h = HP[u]; n = s + t + h;
    cap = (u == 1) ? sv + 16'(t - 1) : sv;
    wt = 0;
    while (!ready[u] && wt < 50) begin
      @(negedge clock);
      wt++;
    end
    check("ready_wait", 32'(ready[u]), 32'd1);
    sval[u]  = sv;
    valid[u] = 1'b1;
    write[u] = wr;
    add[u]   = a;
    wdata[u] = wd;
    @(posedge clock);
    #1;
    add[u]   = 6'($urandom);
    wdata[u] = 16'($urandom);
    write[u] = 1'($urandom);
    if (!hold_next) valid[u] = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      in_str = (k > s) && (k <= s + t);
      exp_rd = (!wr && k > s + t) ? cap : last_rd[u];
      check("ce",    32'(ce[u]),    32'd0);
      check("we",    32'(we[u]),    32'(!(wr && in_str)));
      check("oe",    32'(oe[u]),    32'(!(!wr && in_str)));
      check("doe",   32'(doe[u]),   32'(wr));
      check("add",   32'(madd[u]),  32'(a));
      check("ready", 32'(ready[u]), 32'd0);
      check("busy",  32'(busy[u]),  32'd1);
      check("rvld",  32'(rvld[u]),  32'(!wr && k == s + t + 1));
      check("rdata", 32'(rdata[u]), 32'(exp_rd));
      check("no_overlap", 32'(!we[u] && !oe[u]), 32'd0);
      if (wr) check("dout", 32'(dout[u]), 32'(wd));
    end
    @(negedge clock);
    check("end_ce",    32'(ce[u]),    32'd1);
    check("end_we",    32'(we[u]),    32'd1);
    check("end_oe",    32'(oe[u]),    32'd1);
    check("end_doe",   32'(doe[u]),   32'd0);
    check("end_ready", 32'(ready[u]), 32'd1);
    check("end_rvld",  32'(rvld[u]),  32'd0);
    if (!wr) last_rd[u] = cap;
  endtask

  typedef struct {
    int          u;
    bit          wr;
    logic [5:0]  a;
    logic [15:0] wd;
    logic [15:0] sv;
    bit          hold;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{0, 1'b1, 6'h06, 16'hA55A, 16'h0000, 1'b0};
    vecs[1] = '{0, 1'b0, 6'h03, 16'h0000, 16'h1234, 1'b0};
    vecs[2] = '{0, 1'b1, 6'h2A, 16'h0F0F, 16'h0000, 1'b1};
    vecs[3] = '{0, 1'b0, 6'h15, 16'h0000, 16'hC3C3, 1'b0};
    vecs[4] = '{1, 1'b1, 6'h3F, 16'hFFFF, 16'h0000, 1'b0};
    vecs[5] = '{1, 1'b0, 6'h01, 16'h0000, 16'h7770, 1'b0};
    vecs[6] = '{0, 1'b0, 6'h00, 16'h0000, 16'h8001, 1'b0};

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      valid[i] = 1'b0; write[i] = 1'b0; add[i] = '0; wdata[i] = '0;
      sval[i] = '0; last_rd[i] = '0;
    end
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check("rst_ce",    32'(ce[i]),    32'd1);
      check("rst_oe",    32'(oe[i]),    32'd1);
      check("rst_we",    32'(we[i]),    32'd1);
      check("rst_doe",   32'(doe[i]),   32'd0);
      check("rst_ready", 32'(ready[i]), 32'd1);
      check("rst_busy",  32'(busy[i]),  32'd0);
      check("rst_rvld",  32'(rvld[i]),  32'd0);
      check("rst_rdata", 32'(rdata[i]), 32'd0);
      check("rst_add",   32'(madd[i]),  32'd0);
      check("rst_dout",  32'(dout[i]),  32'd0);
    end

    for (int i = 0; i < 7; i++)
      run_txn(vecs[i].u, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].sv, vecs[i].hold);

    // Reset during the second STROBE cycle of a read on unit 0.
    sval[0] = 16'hBEEF; valid[0] = 1'b1; write[0] = 1'b0; add[0] = 6'h3E;
    @(posedge clock);
    #1 valid[0] = 1'b0;
    repeat (SP[0] + 1) @(posedge clock);
    #1;
    check("pre_rst_oe", 32'(oe[0]), 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("abort_ce",    32'(ce[0]),    32'd1);
    check("abort_oe",    32'(oe[0]),    32'd1);
    check("abort_doe",   32'(doe[0]),   32'd0);
    check("abort_ready", 32'(ready[0]), 32'd1);
    check("abort_rdata", 32'(rdata[0]), 32'd0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check("abort_rvld", 32'(rvld[0]), 32'd0);
    end
    run_txn(0, 1'b1, 6'h11, 16'h5AA5, 16'h0000, 1'b0);

    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 15; i++)
        run_txn(u, 1'($urandom), 6'($urandom), 16'($urandom), 16'($urandom),
                (i < 14) ? 1'($urandom) : 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
